// File: rtl/adc_sample_averager.sv
// Boxcar averager: sums 2**LOG2_SAMPLES prescaled samples and publishes the truncated mean.
// Optional per-window min/max tracking is built when ADC_AVG_MINMAX_EN is defined.
module adc_sample_averager #(
  parameter int WIDTH        = 10,
  parameter int LOG2_SAMPLES = 3,
  parameter int SAMPLE_DIV   = 1200
) (
  input  logic                    clk12MHz,
  input  logic                    reset,
  input  logic [WIDTH-1:0]        sample_in,
  input  logic                    clear,
  output logic [WIDTH-1:0]        avg_out,
  output logic                    avg_valid,
  output logic                    primed,
  output logic [LOG2_SAMPLES-1:0] window_pos,
  output logic [WIDTH-1:0]        min_out,
  output logic [WIDTH-1:0]        max_out
);
  localparam int PW = $clog2(SAMPLE_DIV);
  localparam int AW = WIDTH + LOG2_SAMPLES;
  localparam logic [PW-1:0]           DIV_LAST = PW'(SAMPLE_DIV - 1);
  localparam logic [LOG2_SAMPLES-1:0] POS_LAST = '1;

  typedef enum logic {FILL, RUN} state_t;

  state_t        state_reg;
  logic [PW-1:0] presc_reg;
  logic [AW-1:0] acc_reg;
  logic [AW-1:0] acc_sum;
  logic          tick;
  logic          window_done;

  assign tick        = (presc_reg == DIV_LAST);
  assign window_done = tick && (window_pos == POS_LAST);
  // The accumulator carries LOG2_SAMPLES guard bits, so a full window of all-ones is exact.
  assign acc_sum     = acc_reg + AW'(sample_in);

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      state_reg  <= FILL;
      presc_reg  <= '0;
      acc_reg    <= '0;
      window_pos <= '0;
      avg_out    <= '0;
      avg_valid  <= 1'b0;
      primed     <= 1'b0;
    end else begin
      avg_valid <= 1'b0;
      if (clear) begin
        presc_reg  <= '0;
        acc_reg    <= '0;
        window_pos <= '0;
      end else begin
        presc_reg <= tick ? '0 : presc_reg + 1'b1;
        if (tick) begin
          window_pos <= window_pos + 1'b1;
          if (window_done) begin
            acc_reg   <= '0;
            avg_out   <= acc_sum[AW-1:LOG2_SAMPLES];
            avg_valid <= 1'b1;
            case (state_reg)
              FILL: begin
                state_reg <= RUN;
                primed    <= 1'b1;
              end
              default: begin
                state_reg <= RUN;
                primed    <= 1'b1;
              end
            endcase
          end else begin
            acc_reg <= acc_sum;
          end
        end
      end
    end
  end

`ifdef ADC_AVG_MINMAX_EN
  logic [WIDTH-1:0] run_min_reg;
  logic [WIDTH-1:0] run_max_reg;
  logic [WIDTH-1:0] min_next;
  logic [WIDTH-1:0] max_next;

  // Position 0 marks the first sample of a window, which loads both trackers.
  always_comb begin
    min_next = run_min_reg;
    max_next = run_max_reg;
    if (window_pos == '0) begin
      min_next = sample_in;
      max_next = sample_in;
    end else begin
      if (sample_in < run_min_reg) min_next = sample_in;
      if (sample_in > run_max_reg) max_next = sample_in;
    end
  end

  always_ff @(posedge clk12MHz) begin
    if (reset) begin
      run_min_reg <= '0;
      run_max_reg <= '0;
      min_out     <= '0;
      max_out     <= '0;
    end else if (clear) begin
      run_min_reg <= '0;
      run_max_reg <= '0;
    end else if (tick) begin
      run_min_reg <= min_next;
      run_max_reg <= max_next;
      if (window_done) begin
        min_out <= min_next;
        max_out <= max_next;
      end
    end
  end
`else
  assign min_out = '0;
  assign max_out = '0;
`endif

endmodule

// File: tb/tb_adc_sample_averager.sv
// Directed bench for adc_sample_averager with SAMPLE_DIV=4 (ticks every 4th cycle, 32-cycle window).
module tb_adc_sample_averager;
  localparam int WIDTH        = 10;
  localparam int LOG2_SAMPLES = 3;
  localparam int SAMPLE_DIV   = 4;
`ifdef ADC_AVG_MINMAX_EN
  localparam int MM = 1;
`else
  localparam int MM = 0;
`endif

  logic                    clk12MHz = 1'b0;
  logic                    reset    = 1'b1;
  logic                    clear    = 1'b0;
  logic [WIDTH-1:0]        sample_in = '0;
  logic [WIDTH-1:0]        avg_out;
  logic                    avg_valid;
  logic                    primed;
  logic [LOG2_SAMPLES-1:0] window_pos;
  logic [WIDTH-1:0]        min_out;
  logic [WIDTH-1:0]        max_out;

  adc_sample_averager #(
    .WIDTH(WIDTH), .LOG2_SAMPLES(LOG2_SAMPLES), .SAMPLE_DIV(SAMPLE_DIV)
  ) dut (
    .clk12MHz(clk12MHz), .reset(reset), .sample_in(sample_in), .clear(clear),
    .avg_out(avg_out), .avg_valid(avg_valid), .primed(primed),
    .window_pos(window_pos), .min_out(min_out), .max_out(max_out)
  );

  always #5 clk12MHz = ~clk12MHz;

  int compared    = 0;
  int mismatched  = 0;
  int cyc         = 0;
  int phase       = 0;
  int valid_count = 0;
  int valid_cyc   = -1;
  int valid_avg   = -1;
  logic [WIDTH-1:0] win [8];

  function automatic int mm(input int v);
    return (MM != 0) ? v : 0;
  endfunction

  task automatic check_value(input string tag, input int obs, input int exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end else begin
      $display("ok   %s: %0d (cycle %0d)", tag, obs, cyc);
    end
  endtask

  // Apply inputs for the current cycle, cross the edge, land in the next cycle.
  task automatic step(input logic [WIDTH-1:0] s, input logic c);
    sample_in = s;
    clear     = c;
    @(posedge clk12MHz);
    #1;
    cyc++;
    if (avg_valid === 1'b1) begin
      valid_count++;
      valid_cyc = cyc;
      valid_avg = int'(avg_out);
    end
  endtask

  // Sample for tick k (cycle phase+4k+3) is held for the whole 4-cycle slot.
  task automatic feed(input int n);
    for (int i = 0; i < n; i++) step(win[((cyc - phase) / SAMPLE_DIV) % 8], 1'b0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    clear = 1'b0;
    @(posedge clk12MHz);
    #1;
    reset       = 1'b0;
    cyc         = 0;
    phase       = 0;
    valid_count = 0;
    valid_cyc   = -1;
    valid_avg   = -1;
  endtask

  task automatic fill_win(input logic [WIDTH-1:0] v);
    for (int i = 0; i < 8; i++) win[i] = v;
  endtask

  initial begin
    // Reset state
    do_reset();
    check_value("rst_avg_out", int'(avg_out), 0);
    check_value("rst_avg_valid", int'(avg_valid), 0);
    check_value("rst_primed", int'(primed), 0);
    check_value("rst_window_pos", int'(window_pos), 0);
    check_value("rst_min_out", int'(min_out), 0);
    check_value("rst_max_out", int'(max_out), 0);

    // Constant 512
    fill_win(10'd512);
    feed(16);
    check_value("const_pos_after_4_ticks", int'(window_pos), 4);
    feed(15);
    check_value("const_no_early_valid", valid_count, 0);
    check_value("const_primed_before", int'(primed), 0);
    feed(1);
    check_value("const_valid_at_32", int'(avg_valid), 1);
    check_value("const_avg", int'(avg_out), 512);
    check_value("const_primed_after", int'(primed), 1);
    check_value("const_pos_wrapped", int'(window_pos), 0);
    feed(1);
    check_value("const_valid_one_cycle", int'(avg_valid), 0);
    check_value("const_avg_held", int'(avg_out), 512);

    // Ramp 0..7, then a shuffled window
    do_reset();
    for (int i = 0; i < 8; i++) win[i] = 10'(i);
    feed(32);
    check_value("ramp_valid_cyc", valid_cyc, 32);
    check_value("ramp_avg", valid_avg, 3);
    check_value("ramp_min", int'(min_out), mm(0));
    check_value("ramp_max", int'(max_out), mm(7));
    win[0] = 10'd50; win[1] = 10'd30; win[2] = 10'd70; win[3] = 10'd10;
    win[4] = 10'd90; win[5] = 10'd40; win[6] = 10'd60; win[7] = 10'd20;
    feed(32);
    check_value("mix_valid_cyc", valid_cyc, 64);
    check_value("mix_valid_count", valid_count, 2);
    check_value("mix_avg", int'(avg_out), 46);
    check_value("mix_min", int'(min_out), mm(10));
    check_value("mix_max", int'(max_out), mm(90));

    // Full scale then zero
    do_reset();
    fill_win(10'd1023);
    feed(32);
    check_value("full_avg", valid_avg, 1023);
    check_value("full_min", int'(min_out), mm(1023));
    check_value("full_max", int'(max_out), mm(1023));
    fill_win(10'd0);
    feed(32);
    check_value("zero_valid_count", valid_count, 2);
    check_value("zero_avg", int'(avg_out), 0);
    check_value("zero_max", int'(max_out), 0);
    check_value("zero_primed", int'(primed), 1);

    // Clear mid-window at cycle 17
    do_reset();
    fill_win(10'd100);
    feed(17);
    check_value("clr_pos_before", int'(window_pos), 4);
    step(10'd100, 1'b1);
    check_value("clr_pos_after", int'(window_pos), 0);
    check_value("clr_avg_kept", int'(avg_out), 0);
    phase = cyc;
    fill_win(10'd200);
    feed(32);
    check_value("clr_valid_count", valid_count, 1);
    check_value("clr_valid_cyc", valid_cyc, 50);
    check_value("clr_avg", valid_avg, 200);
    check_value("clr_min", int'(min_out), mm(200));

    // Clear on a tick cycle discards that sample
    do_reset();
    fill_win(10'd8);
    feed(3);
    step(10'd1000, 1'b1);
    check_value("clrtick_pos", int'(window_pos), 0);
    phase = cyc;
    feed(32);
    check_value("clrtick_valid_count", valid_count, 1);
    check_value("clrtick_valid_cyc", valid_cyc, 36);
    check_value("clrtick_avg", valid_avg, 8);
    check_value("clrtick_max", int'(max_out), mm(8));

    // Reset after 5 ticks in RUN
    do_reset();
    fill_win(10'd300);
    feed(52);
    check_value("rstmid_primed", int'(primed), 1);
    check_value("rstmid_pos", int'(window_pos), 5);
    check_value("rstmid_max_pre", int'(max_out), mm(300));
    do_reset();
    check_value("rstmid_avg_out", int'(avg_out), 0);
    check_value("rstmid_primed_clr", int'(primed), 0);
    check_value("rstmid_pos_clr", int'(window_pos), 0);
    check_value("rstmid_max_clr", int'(max_out), 0);
    check_value("rstmid_valid", int'(avg_valid), 0);
    fill_win(10'd40);
    feed(31);
    check_value("rstmid_no_early_valid", valid_count, 0);
    feed(1);
    check_value("rstmid_valid_cyc", valid_cyc, 32);
    check_value("rstmid_avg", valid_avg, 40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
